regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the 16x32 single-write register file.
- Adds configurable depth and width, per-byte write strobes, two registered read ports with write-to-read bypass, and a sticky address-error flag.
- Sits between the datapath bus (write side) and the ALU operand latches (read side) of the CPU.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 16, number of registers; range 2..256.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- BE_W, DATA_W/8, byte-enable width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers bits [8i+7:8i].
- rd0_en  in  1  read port 0 request.
- rd0_addr  in  ADDR_W  read port 0 address.
- rd0_data  out  DATA_W  read port 0 data, registered.
- rd1_en  in  1  read port 1 request.
- rd1_addr  in  ADDR_W  read port 1 address.
- rd1_data  out  DATA_W  read port 1 data, registered.
- addr_err  out  1  sticky out-of-range access flag.
- err_clr  in  1  synchronous clear of addr_err.

Behaviour:
- Reset (clr low, asynchronous):
  - All NUM_REGS registers go to 0.
  - rd0_data and rd1_data go to 0; addr_err goes to 0.
  - Reset asserted mid-operation discards any in-flight write or read on that edge.
- Write:
  - Happens at posedge clk when wr_en=1 and wr_addr<NUM_REGS.
  - Byte i of the register takes wr_data byte i where wr_be[i]=1; otherwise keeps its old byte.
  - wr_be=0 with wr_en=1 is a legal no-op.
- Read:
  - Latency is 1 cycle. On posedge with rdN_en=1, rdN_data <= contents of rdN_addr.
  - With rdN_en=0, rdN_data holds its previous value.
  - The two ports are independent; both may address the same register.
- Bypass (write-first):
  - If rdN_en=1, rdN_addr==wr_addr, and the write is valid on the same edge, rdN_data takes the byte-merged new value (old bytes where wr_be=0, new bytes where wr_be=1).
  - It never returns pre-write data.
- Out-of-range (address >= NUM_REGS):
  - Write: storage is unchanged and addr_err is set.
  - Read with rdN_en=1: rdN_data <= 0 and addr_err is set.
  - Out-of-range is only possible when NUM_REGS < 2**ADDR_W.
- addr_err:
  - Set on any out-of-range access; cleared at posedge when err_clr=1.
  - If a set and err_clr occur on the same edge, set wins (addr_err=1).
- No state machine. The block consists of the storage array, two output registers and one flag flop.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0.
  - Writes to address 0 are silently ignored and do not set addr_err.
  - Reads of address 0 return 0, including under bypass.
  - No flops are instantiated for register 0.
- Undefined: register 0 is an ordinary register, identical to all others.

Decomposition:
- Package regfile_pkg holds:
  - Constants RF_DATA_W_DEF=32 and RF_NUM_REGS_DEF=16.
  - Function byte_merge(old, new, be) returning the strobe-merged word, used by both storage update and bypass.
- One natural sub-module, regfile_rd_port: one registered read port containing the mux, bypass compare, range check and output flop. It is instantiated twice and exports a per-port error pulse to the top, which ORs the pulses into addr_err.

Test Plan:
- Reset release: hold clr=0, then release; read all 16 addresses on both ports -> every rd_data=0x00000000 one cycle after request; addr_err=0.
- Byte strobes: write 0xAABBCCDD to R5 with wr_be=1111, then 0x11223344 with wr_be=0101; read R5 -> 0xAA22CC44.
- Bypass: same edge, write 0xDEADBEEF to R3 (wr_be=1111) and rd0_addr=3, rd1_addr=3 -> both ports 0xDEADBEEF next cycle. Repeat with wr_be=0011 over a stored 0x12345678 -> 0x1234BEEF.
- Hold and independence: rd0_en=0 for 3 cycles while R2 is rewritten -> rd0_data unchanged. Meanwhile rd1 reads R2 -> rd1_data tracks the new value.
- Error flag, NUM_REGS=12 / ADDR_W=4:
  - Write to address 13 -> storage unchanged, addr_err=1.
  - Read address 14 -> rd_data=0.
  - err_clr together with a new bad read -> addr_err stays 1.
  - err_clr alone -> addr_err=0.
- With REGFILE_R0_ZERO_EN: write 0xFFFFFFFF to R0, then read R0 on both ports -> 0x00000000 and addr_err=0. Without the macro -> 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Shared constants and the byte-strobe merge helper for regfile_2r1w.
// Rev    : 1.0  initial parametrised 2R1W register file
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int RF_DATA_W_DEF   = 32;
    localparam int RF_NUM_REGS_DEF = 16;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int RF_MAX_DATA_W   = 512;
    localparam int RF_MAX_BE_W     = RF_MAX_DATA_W / 8;

    function automatic logic [RF_MAX_DATA_W-1:0] byte_merge(
        input logic [RF_MAX_DATA_W-1:0] old_word,
        input logic [RF_MAX_DATA_W-1:0] new_word,
        input logic [RF_MAX_BE_W-1:0]   be
    );
        logic [RF_MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < RF_MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module : regfile_rd_port
// One registered read port: address mux, write-first bypass, range check.
// Rev    : 1.0  initial parametrised 2R1W register file
// ============================================================================
`default_nettype none

module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem [NUM_REGS],
    input  logic              i_wr_ok,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W/8-1:0] i_wr_be,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_err
);

    logic              w_in_range;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_data;

    assign w_in_range = (32'(i_rd_addr) < NUM_REGS);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == ADDR_W'(i)) begin
                w_word = i_mem[i];
            end
        end
        w_next = '0;
        if (w_in_range) begin
            // Write-first: a same-edge write to this address is visible now.
            if (i_wr_ok && (i_wr_addr == i_rd_addr)) begin
                w_next = DATA_W'(byte_merge(RF_MAX_DATA_W'(w_word),
                                            RF_MAX_DATA_W'(i_wr_data),
                                            RF_MAX_BE_W'(i_wr_be)));
            end else begin
                w_next = w_word;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_data <= '0;
        end else if (i_rd_en) begin
            r_data <= w_next;
        end
    end

    assign o_rd_data = r_data;
    assign o_err     = i_rd_en && !w_in_range;

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module : regfile_2r1w
// Byte-strobed 1W/2R register file with bypass and sticky address error.
// Optional macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
// Rev    : 1.0  initial parametrised 2R1W register file
// ============================================================================
`default_nettype none

module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd0_en,
    input  logic [ADDR_W-1:0]   rd0_addr,
    output logic [DATA_W-1:0]   rd0_data,
    input  logic                rd1_en,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    output logic                addr_err,
    input  logic                err_clr
);

    localparam int BE_W = DATA_W / 8;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit c_R0_ZERO = 1'b1;
`else
    localparam bit c_R0_ZERO = 1'b0;
`endif

    logic              w_wr_in_range;
    logic              w_wr_ok;
    logic              w_wr_err;
    logic              w_rd0_err;
    logic              w_rd1_err;
    logic [DATA_W-1:0] w_mem [NUM_REGS];
    logic              r_addr_err;

    assign w_wr_in_range = (32'(wr_addr) < NUM_REGS);
    assign w_wr_ok  = wr_en && w_wr_in_range && !(c_R0_ZERO && (wr_addr == '0));
    assign w_wr_err = wr_en && !w_wr_in_range;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (c_R0_ZERO && (g == 0)) begin : g_zero
            assign w_mem[g] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] r_q;
            logic [DATA_W-1:0] w_merged;

            assign w_merged = DATA_W'(byte_merge(RF_MAX_DATA_W'(r_q),
                                                 RF_MAX_DATA_W'(wr_data),
                                                 RF_MAX_BE_W'(wr_be)));

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_q <= '0;
                end else if (w_wr_ok && (wr_addr == ADDR_W'(g))) begin
                    r_q <= w_merged;
                end
            end

            assign w_mem[g] = r_q;
        end
    end

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd0 (
        .clk       (clk),
        .clr       (clr),
        .i_rd_en   (rd0_en),
        .i_rd_addr (rd0_addr),
        .i_mem     (w_mem),
        .i_wr_ok   (w_wr_ok),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_wr_be   (wr_be),
        .o_rd_data (rd0_data),
        .o_err     (w_rd0_err)
    );

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd1 (
        .clk       (clk),
        .clr       (clr),
        .i_rd_en   (rd1_en),
        .i_rd_addr (rd1_addr),
        .i_mem     (w_mem),
        .i_wr_ok   (w_wr_ok),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_wr_be   (wr_be),
        .o_rd_data (rd1_data),
        .o_err     (w_rd1_err)
    );

    // A new error on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_addr_err <= 1'b0;
        end else if (w_wr_err || w_rd0_err || w_rd1_err) begin
            r_addr_err <= 1'b1;
        end else if (err_clr) begin
            r_addr_err <= 1'b0;
        end
    end

    assign addr_err = r_addr_err;

    logic w_unused;
    assign w_unused = ^BE_W;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// Module : tb_regfile_2r1w
// Directed and random checks of regfile_2r1w (12 regs, 4-bit address).
// Rev    : 1.0  initial bench
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

    localparam int NREGS = 12;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd0_en = 1'b0;
    logic [3:0]  rd0_addr = '0;
    logic [31:0] rd0_data;
    logic        rd1_en = 1'b0;
    logic [3:0]  rd1_addr = '0;
    logic [31:0] rd1_data;
    logic        addr_err;
    logic        err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [16];
    logic [31:0] exp0 = '0;
    logic [31:0] exp1 = '0;
    logic        exp_err = 1'b0;

    regfile_2r1w #(
        .DATA_W   (32),
        .NUM_REGS (NREGS),
        .ADDR_W   (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd0_en   (rd0_en),
        .rd0_addr (rd0_addr),
        .rd0_data (rd0_data),
        .rd1_en   (rd1_en),
        .rd1_addr (rd1_addr),
        .rd1_data (rd1_data),
        .addr_err (addr_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: apply the write to the array first, then reads see the
    // updated array (write-first); out-of-range reads give zero.
    task automatic cyc(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input logic e0, input logic [3:0] a0,
                       input logic e1, input logic [3:0] a1, input logic ec);
        logic bad;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1; err_clr = ec;
        @(posedge clk);
        bad = 1'b0;
        if (we) begin
            if (int'(wa) >= NREGS) bad = 1'b1;
            else if (!(R0Z && wa == 4'd0)) begin
                for (int b = 0; b < 4; b++)
                    if (wbe[b]) mdl[wa][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (e0) begin
            if (int'(a0) >= NREGS) begin bad = 1'b1; exp0 = '0; end
            else exp0 = mdl[a0];
        end
        if (e1) begin
            if (int'(a1) >= NREGS) begin bad = 1'b1; exp1 = '0; end
            else exp1 = mdl[a1];
        end
        if (bad) exp_err = 1'b1;
        else if (ec) exp_err = 1'b0;
        #1;
        chk("rd0_data", rd0_data, exp0);
        chk("rd1_data", rd1_data, exp1);
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        // Reset held, then released away from the clock edge.
        @(posedge clk); @(posedge clk); #1;
        chk("reset_rd0", rd0_data, 32'h0);
        chk("reset_rd1", rd1_data, 32'h0);
        chk("reset_err", {31'b0, addr_err}, 32'h0);
        clr = 1'b1;

        for (int i = 0; i < NREGS; i++)
            cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b1, 4'(NREGS - 1 - i), 1'b0);

        // Byte strobes
        cyc(1'b1, 4'd5, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd5, 32'h11223344, 4'h5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        chk("byte_strobe", rd0_data, 32'hAA22CC44);

        // Bypass, full and partial strobes
        cyc(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        chk("bypass_full0", rd0_data, 32'hDEADBEEF);
        chk("bypass_full1", rd1_data, 32'hDEADBEEF);
        cyc(1'b1, 4'd3, 32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 4'd3, 32'hDEADBEEF, 4'h3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        chk("bypass_part0", rd0_data, 32'h1234BEEF);
        chk("bypass_part1", rd1_data, 32'h1234BEEF);

        // Hold on rd0 while rd1 tracks rewrites of R2
        cyc(1'b1, 4'd7, 32'h77770007, 4'hF, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 4'd2, 32'hC0DE0000 + 32'(k), 4'hF, 1'b0, 4'd2, 1'b1, 4'd2, 1'b0);
            chk("hold_rd0", rd0_data, 32'h77770007);
            chk("track_rd1", rd1_data, 32'hC0DE0000 + 32'(k));
        end

        // Out-of-range accesses and sticky flag
        cyc(1'b1, 4'd13, 32'hBAD0BAD0, 4'hF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        chk("err_bad_wr", {31'b0, addr_err}, 32'h1);
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd14, 1'b0, 4'd0, 1'b0);
        chk("bad_rd_zero", rd0_data, 32'h0);
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1, 4'd15, 1'b1);
        chk("clr_vs_set", {31'b0, addr_err}, 32'h1);
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        chk("clr_alone", {31'b0, addr_err}, 32'h0);
        for (int i = 0; i < NREGS; i++)
            cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b1, 4'(i), 1'b0);

        // Register 0 behaviour
        cyc(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0);
        chk("r0_rd0", rd0_data, R0Z ? 32'h0 : 32'hFFFFFFFF);
        chk("r0_rd1", rd1_data, R0Z ? 32'h0 : 32'hFFFFFFFF);
        chk("r0_err", {31'b0, addr_err}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset mid-operation clears everything
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h55AA55AA; wr_be = 4'hF;
        rd0_en = 1'b1; rd0_addr = 4'd4; rd1_en = 1'b1; rd1_addr = 4'd14;
        #2 clr = 1'b0;
        #1;
        chk("async_rd0", rd0_data, 32'h0);
        chk("async_err", {31'b0, addr_err}, 32'h0);
        @(posedge clk); #1;
        chk("inrst_rd1", rd1_data, 32'h0);
        clr = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        exp0 = '0; exp1 = '0; exp_err = 1'b0;
        cyc(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd4, 1'b1, 4'd5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
